// File: rtl/pong_ball_match_ctrl.sv
// Ball and match controller for the pong datapath.
// Moves the ball once per frame and bounces it off the top and bottom walls
// and off the paddles. Paddle hits set the vertical deflection from the hit
// zone and ramp up the horizontal speed. The block also scores misses and
// runs the IDLE -> SERVE -> PLAY -> OVER match sequence.
//
// Interface timing: new_frame_i is a one-cycle strobe and has no
// back-pressure. hit_left_i, hit_right_i and hit_zone_i are sampled every
// cycle in PLAY. A hit counts once, because accepting it reverses dir_x, and
// the hit is then moving away from the paddle. start_i is a level, and only
// its rising edge matters, in IDLE and OVER. All outputs come straight from
// flops, so they change on the clock after the event that caused them.
module pong_ball_match_ctrl #(
  parameter int X_POS_W      = 10,
  parameter int Y_POS_W      = 10,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BORDER       = 10,
  parameter int BALL_SIDE    = 8,
  parameter int SPEED_W      = 4,
  parameter int INIT_SPEED   = 2,
  parameter int MAX_SPEED    = 6,
  parameter int RAMP_HITS    = 4,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic               start_i,
  input  logic               hit_left_i,
  input  logic               hit_right_i,
  input  logic [1:0]         hit_zone_i,
  input  logic [3:0]         rnd_i,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic [SCORE_W-1:0] score_l_o,
  output logic [SCORE_W-1:0] score_r_o,
  output logic [1:0]         state_o,
  output logic               game_over_o,
  output logic               winner_o
);

  // Match states, also exported on state_o for debug and checkers.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // One extra bit for the arithmetic, so that sums and edge tests never wrap.
  localparam int XW1  = X_POS_W + 1;
  localparam int YW1  = Y_POS_W + 1;
  localparam int HC_W = (RAMP_HITS > 1) ? $clog2(RAMP_HITS) : 1;
  localparam int FC_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [X_POS_W-1:0] CX       = X_POS_W'((H_RES - BALL_SIDE) / 2);
  localparam logic [Y_POS_W-1:0] CY       = Y_POS_W'((V_RES - BALL_SIDE) / 2);
  localparam logic [X_POS_W-1:0] X_MAX_N  = X_POS_W'(H_RES - BALL_SIDE);
  localparam logic [X_POS_W-1:0] X_BRD_N  = X_POS_W'(BORDER);
  localparam logic [XW1-1:0]     X_SIDE   = XW1'(BALL_SIDE);
  localparam logic [XW1-1:0]     X_GOAL_R = XW1'(H_RES - BORDER);
  localparam logic [Y_POS_W-1:0] Y_MIN_N  = Y_POS_W'(BORDER);
  localparam logic [Y_POS_W-1:0] Y_MAX_N  = Y_POS_W'(V_RES - BORDER - BALL_SIDE);
  localparam logic [YW1-1:0]     Y_SIDE   = YW1'(BALL_SIDE);
  localparam logic [YW1-1:0]     Y_WALL_B = YW1'(V_RES - BORDER);
  localparam logic [SPEED_W-1:0] V_INIT   = SPEED_W'(INIT_SPEED);
  localparam logic [SPEED_W-1:0] V_MAX    = SPEED_W'(MAX_SPEED);
  localparam logic [HC_W-1:0]    HC_LAST  = HC_W'(RAMP_HITS - 1);
  localparam logic [FC_W-1:0]    FC_LAST  = FC_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SC_WIN   = SCORE_W'(WIN_SCORE);

  // Registered state
  logic [1:0]         state_q,     state_d;
  logic [X_POS_W-1:0] ball_x_q,    ball_x_d;
  logic [Y_POS_W-1:0] ball_y_q,    ball_y_d;
  logic [SCORE_W-1:0] score_l_q,   score_l_d;
  logic [SCORE_W-1:0] score_r_q,   score_r_d;
  logic [SPEED_W-1:0] vx_q,        vx_d;
  logic [SPEED_W-1:0] vy_q,        vy_d;
  logic               dir_x_q,     dir_x_d;     // 1 = moving left
  logic               dir_y_q,     dir_y_d;     // 1 = moving up
  logic [HC_W-1:0]    hit_cnt_q,   hit_cnt_d;
  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic               game_over_q, game_over_d;
  logic               winner_q,    winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               start_q,     start_d;

  // Intermediate values
  logic               start_re;
  logic               hit_acc;
  logic               dir_x_h, dir_y_h;
  logic [SPEED_W-1:0] vx_h, vy_h;
  logic [HC_W-1:0]    hit_cnt_h;
  logic               miss_r, miss_l;
  logic               dir_y_w;
  logic [XW1-1:0]     x_ext, x_up;
  logic [X_POS_W-1:0] x_dn, x_move;
  logic [YW1-1:0]     y_ext, y_up_lim, y_dn_sum;
  logic [Y_POS_W-1:0] y_up, y_move;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  assign start_d  = start_i;
  assign start_re = start_i & ~start_q;

  // A paddle hit counts only while the ball is moving toward that paddle.
  assign hit_acc = (state_q == ST_PLAY) &&
                   ((hit_left_i && dir_x_q) || (hit_right_i && !dir_x_q));

  // Motion parameters after any accepted hit (deflection and speed ramp).
  always_comb begin
    dir_x_h   = dir_x_q;
    dir_y_h   = dir_y_q;
    vx_h      = vx_q;
    vy_h      = vy_q;
    hit_cnt_h = hit_cnt_q;
    if (hit_acc) begin
      dir_x_h = ~dir_x_q;
      if (hit_zone_i == 2'd1) begin
        dir_y_h = 1'b1;
        vy_h    = vx_q;
      end else if (hit_zone_i == 2'd2) begin
        dir_y_h = 1'b0;
        vy_h    = vx_q;
      end
      if (hit_cnt_q == HC_LAST) begin
        hit_cnt_h = '0;
        if (vx_q < V_MAX) vx_h = vx_q + SPEED_W'(1);
      end else begin
        hit_cnt_h = hit_cnt_q + HC_W'(1);
      end
    end
  end

  // Miss detection uses the current position and heading.
  always_comb begin
    x_ext  = {1'b0, ball_x_q};
    miss_r = dir_x_q && (ball_x_q <= X_BRD_N);
    miss_l = !dir_x_q && ((x_ext + X_SIDE) >= X_GOAL_R);
  end

  // Wall bounce, then the next position with edge saturation.
  always_comb begin
    y_ext   = {1'b0, ball_y_q};
    dir_y_w = dir_y_h;
    if (dir_y_h && (ball_y_q <= Y_MIN_N)) begin
      dir_y_w = 1'b0;
    end else if (!dir_y_h && ((y_ext + Y_SIDE) >= Y_WALL_B)) begin
      dir_y_w = 1'b1;
    end

    // The horizontal position saturates at the screen edges. A miss is
    // caught on the next frame.
    x_up = x_ext + XW1'(vx_h);
    x_dn = ball_x_q - X_POS_W'(vx_h);
    if (dir_x_h) begin
      x_move = (x_ext < XW1'(vx_h)) ? '0 : x_dn;
    end else begin
      x_move = (x_up > {1'b0, X_MAX_N}) ? X_MAX_N : x_up[X_POS_W-1:0];
    end

    // The vertical position is clamped inside the play field.
    y_up_lim = {1'b0, Y_MIN_N} + YW1'(vy_h);
    y_up     = ball_y_q - Y_POS_W'(vy_h);
    y_dn_sum = y_ext + YW1'(vy_h);
    if (dir_y_w) begin
      y_move = (y_ext < y_up_lim) ? Y_MIN_N : y_up;
    end else begin
      y_move = (y_dn_sum > {1'b0, Y_MAX_N}) ? Y_MAX_N : y_dn_sum[Y_POS_W-1:0];
    end
  end

  // Match FSM and next values for all registered state.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    hit_cnt_d   = hit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    score_l_inc = score_l_q + SCORE_W'(1);
    score_r_inc = score_r_q + SCORE_W'(1);

    case (state_q)
      ST_IDLE: begin
        ball_x_d = CX;
        ball_y_d = CY;
        if (start_re) begin
          state_d     = ST_SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = rnd_i[0];
          frame_cnt_d = '0;
        end
      end

      ST_SERVE: begin
        ball_x_d = CX;
        ball_y_d = CY;
        if (new_frame_i) begin
          if (frame_cnt_q == FC_LAST) begin
            state_d     = ST_PLAY;
            frame_cnt_d = '0;
            dir_x_d     = serve_dir_q;
            dir_y_d     = rnd_i[1];
            vy_d        = SPEED_W'(rnd_i[3:2]);
            vx_d        = V_INIT;
            hit_cnt_d   = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (new_frame_i && !hit_acc && (miss_r || miss_l)) begin
          // Point scored. Re-centre the ball and reset its speed. The ball
          // does not move on this frame.
          ball_x_d    = CX;
          ball_y_d    = CY;
          vx_d        = V_INIT;
          vy_d        = '0;
          hit_cnt_d   = '0;
          frame_cnt_d = '0;
          if (miss_r) begin
            score_r_d   = score_r_inc;
            serve_dir_d = 1'b1;
            if (score_r_inc == SC_WIN) begin
              state_d     = ST_OVER;
              game_over_d = 1'b1;
              winner_d    = 1'b1;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            score_l_d   = score_l_inc;
            serve_dir_d = 1'b0;
            if (score_l_inc == SC_WIN) begin
              state_d     = ST_OVER;
              game_over_d = 1'b1;
              winner_d    = 1'b0;
            end else begin
              state_d = ST_SERVE;
            end
          end
        end else begin
          dir_x_d   = dir_x_h;
          dir_y_d   = dir_y_h;
          vx_d      = vx_h;
          vy_d      = vy_h;
          hit_cnt_d = hit_cnt_h;
          if (new_frame_i) begin
            dir_y_d  = dir_y_w;
            ball_x_d = x_move;
            ball_y_d = y_move;
          end
        end
      end

      ST_OVER: begin
        ball_x_d = CX;
        ball_y_d = CY;
        if (start_re) begin
          state_d     = ST_SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          game_over_d = 1'b0;
          serve_dir_d = rnd_i[0];
          frame_cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= CX;
      ball_y_q    <= CY;
      score_l_q   <= '0;
      score_r_q   <= '0;
      vx_q        <= V_INIT;
      vy_q        <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      hit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      serve_dir_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      hit_cnt_q   <= hit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      serve_dir_q <= serve_dir_d;
      start_q     <= start_d;
    end
  end

  assign ball_x_o    = ball_x_q;
  assign ball_y_o    = ball_y_q;
  assign score_l_o   = score_l_q;
  assign score_r_o   = score_r_q;
  assign state_o     = state_q;
  assign game_over_o = game_over_q;
  assign winner_o    = winner_q;

endmodule

// File: tb/tb_pong_ball_match_ctrl.sv
// Testbench for pong_ball_match_ctrl. A behavioural match model, written with
// integer arithmetic from the game rules, predicts every output cycle by
// cycle. Directed scenarios and random scenarios are compared against it.
module tb_pong_ball_match_ctrl;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int BORDER       = 10;
  localparam int BALL_SIDE    = 8;
  localparam int INIT_SPEED   = 2;
  localparam int MAX_SPEED    = 6;
  localparam int RAMP_HITS    = 4;
  localparam int WIN_SCORE    = 7;
  localparam int SERVE_FRAMES = 60;

  // Clock and reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic       new_frame = 1'b0;
  logic       start     = 1'b0;
  logic       hit_l     = 1'b0;
  logic       hit_r     = 1'b0;
  logic [1:0] zone      = 2'd0;
  logic [3:0] rnd       = 4'd0;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score_l, score_r;
  logic [1:0] state;
  logic       game_over, winner;
  logic [31:0] dut_vec;

  pong_ball_match_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .new_frame_i (new_frame),
    .start_i     (start),
    .hit_left_i  (hit_l),
    .hit_right_i (hit_r),
    .hit_zone_i  (zone),
    .rnd_i       (rnd),
    .ball_x_o    (ball_x),
    .ball_y_o    (ball_y),
    .score_l_o   (score_l),
    .score_r_o   (score_r),
    .state_o     (state),
    .game_over_o (game_over),
    .winner_o    (winner)
  );

  assign dut_vec = {state, ball_x, ball_y, score_l, score_r, game_over, winner};

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: match phase 0 idle, 1 serve, 2 play, 3 over.
  int m_state, m_x, m_y, m_vx, m_vy, m_dx, m_dy, m_hits, m_frame;
  int m_sl, m_sr, m_sdir, m_go, m_win, m_start_prev;

  function automatic logic [31:0] exp_vec();
    return {m_state[1:0], m_x[9:0], m_y[9:0], m_sl[3:0], m_sr[3:0], m_go[0], m_win[0]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = (H_RES - BALL_SIDE) / 2; m_y = (V_RES - BALL_SIDE) / 2;
    m_vx = INIT_SPEED; m_vy = 0; m_dx = 0; m_dy = 0; m_hits = 0; m_frame = 0;
    m_sl = 0; m_sr = 0; m_sdir = 0; m_go = 0; m_win = 0; m_start_prev = 0;
  endtask

  task automatic model_point(input int scorer);
    if (scorer == 1) m_sr++; else m_sl++;
    m_x = (H_RES - BALL_SIDE) / 2;
    m_y = (V_RES - BALL_SIDE) / 2;
    m_vx = INIT_SPEED; m_vy = 0; m_hits = 0;
    m_sdir = (scorer == 1) ? 1 : 0;   // serve toward the player who lost the point
    if ((scorer == 1 ? m_sr : m_sl) == WIN_SCORE) begin
      m_state = 3; m_go = 1; m_win = scorer;
    end else begin
      m_state = 1;
    end
  endtask

  task automatic model_step(input logic r, input logic nf, input logic s, input logic hl,
                            input logic hr, input logic [1:0] z, input logic [3:0] rd);
    bit st_re, acc;
    if (!r) begin
      model_reset();
      return;
    end
    st_re = s && (m_start_prev == 0);
    m_start_prev = s ? 1 : 0;
    case (m_state)
      0: if (st_re) begin m_state = 1; m_sl = 0; m_sr = 0; m_sdir = rd[0]; m_frame = 0; end
      1: if (nf) begin
        if (m_frame == SERVE_FRAMES - 1) begin
          m_state = 2; m_frame = 0; m_dx = m_sdir; m_dy = rd[1]; m_vy = rd[3:2];
          m_vx = INIT_SPEED; m_hits = 0;
        end else m_frame++;
      end
      2: begin
        acc = (hl && m_dx == 1) || (hr && m_dx == 0);
        if (acc) begin
          m_dx = 1 - m_dx;
          if (z == 2'd1) begin m_dy = 1; m_vy = m_vx; end
          if (z == 2'd2) begin m_dy = 0; m_vy = m_vx; end
          m_hits++;
          if (m_hits == RAMP_HITS) begin
            m_hits = 0;
            m_vx = (m_vx + 1 > MAX_SPEED) ? MAX_SPEED : m_vx + 1;
          end
        end
        if (nf) begin
          if (!acc && m_dx == 1 && m_x <= BORDER) model_point(1);
          else if (!acc && m_dx == 0 && m_x + BALL_SIDE >= H_RES - BORDER) model_point(0);
          else begin
            if (m_dy == 1 && m_y <= BORDER) m_dy = 0;
            else if (m_dy == 0 && m_y + BALL_SIDE >= V_RES - BORDER) m_dy = 1;
            m_x = (m_dx == 1) ? m_x - m_vx : m_x + m_vx;
            if (m_x < 0) m_x = 0;
            if (m_x > H_RES - BALL_SIDE) m_x = H_RES - BALL_SIDE;
            m_y = (m_dy == 1) ? m_y - m_vy : m_y + m_vy;
            if (m_y < BORDER) m_y = BORDER;
            if (m_y > V_RES - BORDER - BALL_SIDE) m_y = V_RES - BORDER - BALL_SIDE;
          end
        end
      end
      default: if (st_re) begin m_state = 1; m_sl = 0; m_sr = 0; m_go = 0; m_sdir = rd[0]; m_frame = 0; end
    endcase
  endtask

  // Driver: apply one cycle of inputs, advance the model, then sample after the edge.
  task automatic drive(input logic r, input logic nf, input logic s, input logic hl,
                       input logic hr, input logic [1:0] z, input logic [3:0] rd);
    rst_n = r; new_frame = nf; start = s; hit_l = hl; hit_r = hr; zone = z; rnd = rd;
    model_step(r, nf, s, hl, hr, z, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'hF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    n_total++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else n_pass++;
    n_total++; if (ball_x !== 10'd316) $display("FAIL reset_x got=%0d exp=316", ball_x); else n_pass++;
    n_total++; if (ball_y !== 10'd236) $display("FAIL reset_y got=%0d exp=236", ball_y); else n_pass++;
    n_total++; if (score_l !== 4'd0 || score_r !== 4'd0)
      $display("FAIL reset_scores got=%0d:%0d exp=0:0", score_l, score_r); else n_pass++;
    n_total++; if (game_over !== 1'b0 || winner !== 1'b0)
      $display("FAIL reset_flags got=%b%b exp=00", game_over, winner); else n_pass++;
  endtask

  task automatic test_serve();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    n_total++; if (state !== 2'd1) $display("FAIL serve_enter got=%0d exp=1", state); else n_pass++;
    n_total++; if (ball_x !== 10'd316 || ball_y !== 10'd236)
      $display("FAIL serve_centre got=(%0d,%0d) exp=(316,236)", ball_x, ball_y); else n_pass++;
    for (int i = 0; i < SERVE_FRAMES; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
      n_total++;
      if (i < SERVE_FRAMES - 1) begin
        if (dut_vec !== exp_vec()) $display("FAIL serve_wait[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
        else n_pass++;
      end else begin
        if (state !== 2'd2) $display("FAIL serve_launch got=%0d exp=2", state); else n_pass++;
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    n_total++; if (ball_x !== 10'd318 || ball_y !== 10'd236)
      $display("FAIL first_move got=(%0d,%0d) exp=(318,236)", ball_x, ball_y); else n_pass++;
  endtask

  task automatic test_hold_hit_and_ramp();
    int want [3] = '{319, 325, 331};
    int nhits[3] = '{3, 12, 4};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0);
      n_total++; if (dut_vec !== exp_vec()) $display("FAIL hold_hit[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      else n_pass++;
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    n_total++; if (ball_x !== 10'd316) $display("FAIL hold_hit_once got=%0d exp=316", ball_x); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      for (int h = 0; h < nhits[k]; h++)
        drive(1'b1, 1'b0, 1'b0, m_dx == 1, m_dx == 0, 2'd0, 4'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
      n_total++; if (ball_x !== 10'(want[k]) || ball_y !== 10'd236)
        $display("FAIL ramp[%0d] got=(%0d,%0d) exp=(%0d,236)", k, ball_x, ball_y, want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_edge_hit_and_miss();
    int done = 0;
    int sr0, sl0;
    for (int c = 0; c < 2000 && done == 0; c++) begin
      if (m_state == 2 && ((m_dx == 1 && m_x <= BORDER) ||
                           (m_dx == 0 && m_x + BALL_SIDE >= H_RES - BORDER))) begin
        sl0 = score_l; sr0 = score_r;
        drive(1'b1, 1'b1, 1'b0, m_dx == 1, m_dx == 0, 2'($urandom_range(0, 3)), 4'h0);
        n_total++; if (state !== 2'd2 || score_l !== 4'(sl0) || score_r !== 4'(sr0))
          $display("FAIL edge_hit got st=%0d sc=%0d:%0d exp st=2 sc=%0d:%0d", state, score_l, score_r, sl0, sr0);
        else n_pass++;
        n_total++; if (dut_vec !== exp_vec()) $display("FAIL edge_hit_vec got=%h exp=%h", dut_vec, exp_vec());
        else n_pass++;
        done = 1;
      end else begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'($urandom_range(0, 15)));
      end
    end
    if (done == 0) begin n_total++; $display("FAIL edge_hit_timeout got=none exp=edge"); end
    // No more hits: the ball eventually misses.
    sl0 = m_sl; sr0 = m_sr; done = 0;
    for (int c = 0; c < 2000 && done == 0; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
      n_total++; if (dut_vec !== exp_vec()) $display("FAIL miss_run got=%h exp=%h", dut_vec, exp_vec());
      else n_pass++;
      if (m_state != 2) done = 1;
    end
    n_total++;
    if (done == 0 || state !== 2'd1 || ball_x !== 10'd316 || ball_y !== 10'd236 ||
        (score_l + score_r) !== 5'(sl0 + sr0 + 1))
      $display("FAIL miss_point got st=%0d (%0d,%0d) sc=%0d:%0d exp st=1 (316,236) one more point",
               state, ball_x, ball_y, score_l, score_r);
    else n_pass++;
    for (int i = 0; i < SERVE_FRAMES + 1; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    n_total++;
    if (ball_x !== ((score_r != 4'(sr0)) ? 10'd314 : 10'd318))
      $display("FAIL serve_dir got=%0d exp=%0d", ball_x, (score_r != 4'(sr0)) ? 314 : 318);
    else n_pass++;
  endtask

  task automatic test_random_play();
    logic s = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) s = ~s;
      drive(1'b1, 1'($urandom_range(0, 1)), s, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      n_total++; if (dut_vec !== exp_vec()) $display("FAIL random[%0d] got=%h exp=%h", c, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_game_over();
    int cyc = 0;
    while (m_state != 3 && cyc < 20000) begin
      drive(1'b1, 1'b1, (m_state == 0) && (m_start_prev == 0), 1'b0, 1'b0, 2'd0, 4'($urandom_range(0, 15)));
      n_total++; if (dut_vec !== exp_vec()) $display("FAIL to_over[%0d] got=%h exp=%h", cyc, dut_vec, exp_vec());
      else n_pass++;
      cyc++;
    end
    n_total++;
    if (state !== 2'd3 || game_over !== 1'b1 || (winner ? score_r : score_l) !== 4'd7)
      $display("FAIL game_over got st=%0d go=%b win=%b sc=%0d:%0d exp st=3 go=1 winner at 7",
               state, game_over, winner, score_l, score_r);
    else n_pass++;
    n_total++; if (winner !== m_win[0]) $display("FAIL winner got=%b exp=%0d", winner, m_win); else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    n_total++; if (dut_vec !== exp_vec()) $display("FAIL over_frozen got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h5);
    n_total++; if (state !== 2'd1 || score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0)
      $display("FAIL restart got st=%0d sc=%0d:%0d go=%b exp st=1 sc=0:0 go=0", state, score_l, score_r, game_over);
    else n_pass++;
  endtask

  task automatic test_reset_mid_play();
    int cyc = 0;
    while (!(m_state == 2 && (m_sl + m_sr) >= 2 && m_x < 200) && cyc < 5000) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'($urandom_range(0, 15)));
      cyc++;
    end
    n_total++; if (state !== 2'd2) $display("FAIL pre_reset_play got=%0d exp=2", state); else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'hF);
    n_total++; if (dut_vec !== {2'd0, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL mid_play_reset got=%h exp=%h", dut_vec, {2'd0, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0, 1'b0});
    else n_pass++;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    n_total++; if (state !== 2'd1) $display("FAIL post_reset_start got=%0d exp=1", state); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_hold_hit_and_ramp();
    test_edge_hit_and_miss();
    test_random_play();
    test_game_over();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
